// File: rtl/mux_sel_scheduler_pkg.sv
// Shared types and default parameters for the mux select scheduler.
package mux_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PH0   = 2'd1,
      PH1   = 2'd2,
      GUARD = 2'd3
   } state_t;

   localparam int DEF_CNT_W     = 16;
   localparam int DEF_BLANK_CYC = 8;

endpackage

// File: rtl/mux_sel_scheduler_if.sv
// Control, configuration handshake and status bundle of the mux select scheduler.
interface mux_sel_scheduler_if
   import mux_sched_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic             EN;
   logic             TRIG;
   logic [CNT_W-1:0] CFG_N0;
   logic [CNT_W-1:0] CFG_N1;
   logic             CFG_VALID;
   logic             CFG_READY;
   logic             M_SEL;
   logic             BLANK;
   logic             SEL_CHANGED;
   logic             TRIG_MISS;
   logic [CNT_W-1:0] PULSE_CNT;

   modport master (
      output EN, TRIG, CFG_N0, CFG_N1, CFG_VALID,
      input  CFG_READY, M_SEL, BLANK, SEL_CHANGED, TRIG_MISS, PULSE_CNT
   );

   modport slave (
      input  EN, TRIG, CFG_N0, CFG_N1, CFG_VALID,
      output CFG_READY, M_SEL, BLANK, SEL_CHANGED, TRIG_MISS, PULSE_CNT
   );
endinterface

// File: rtl/mux_sel_scheduler.sv
// Alternates the radar output mux between two sources in trigger-counted bursts,
// blanking the output for a guard window around every select change.
module mux_sel_scheduler
   import mux_sched_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int BLANK_CYC = DEF_BLANK_CYC
) (
   input  logic               CLK,
   input  logic               ARESETN,
   mux_sel_scheduler_if.slave bus
);
   localparam int                GCNT_W     = $clog2(BLANK_CYC + 1);
   localparam logic [GCNT_W-1:0] GUARD_LOAD = GCNT_W'(BLANK_CYC);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  a0_reg, a0_next, a1_reg, a1_next;
   logic [CNT_W-1:0]  s0_reg, s0_next, s1_reg, s1_next;
   logic              pending_reg, pending_next;
   logic              target_reg, target_next;
   logic [GCNT_W-1:0] gcnt_reg, gcnt_next;
   logic [CNT_W-1:0]  pulse_reg, pulse_next;
   logic              m_sel_reg, m_sel_next;
   logic              blank_reg, blank_next;
   logic              sel_changed_reg, sel_changed_next;
   logic              trig_miss_reg, trig_miss_next;
   logic              cfg_ready_reg, cfg_ready_next;

   logic              cfg_fire;
   logic              enter_ph0;
   logic [CNT_W-1:0]  cand_a0, cand_a1;
   logic [CNT_W-1:0]  cur_len, other_len, pulse_inc;

   assign cfg_fire  = bus.CFG_VALID && cfg_ready_reg;
   // Config that takes effect on PH0 entry: the shadow wins if one is waiting.
   assign cand_a0   = pending_reg ? s0_reg : a0_reg;
   assign cand_a1   = pending_reg ? s1_reg : a1_reg;
   assign cur_len   = (state_reg == PH1) ? a1_reg : a0_reg;
   assign other_len = (state_reg == PH1) ? a0_reg : a1_reg;
   assign pulse_inc = pulse_reg + 1'b1;

   always_ff @(posedge CLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_reg       <= IDLE;
         a0_reg          <= '0;
         a1_reg          <= '0;
         s0_reg          <= '0;
         s1_reg          <= '0;
         pending_reg     <= 1'b0;
         target_reg      <= 1'b0;
         gcnt_reg        <= '0;
         pulse_reg       <= '0;
         m_sel_reg       <= 1'b0;
         blank_reg       <= 1'b0;
         sel_changed_reg <= 1'b0;
         trig_miss_reg   <= 1'b0;
         cfg_ready_reg   <= 1'b1;
      end else begin
         state_reg       <= state_next;
         a0_reg          <= a0_next;
         a1_reg          <= a1_next;
         s0_reg          <= s0_next;
         s1_reg          <= s1_next;
         pending_reg     <= pending_next;
         target_reg      <= target_next;
         gcnt_reg        <= gcnt_next;
         pulse_reg       <= pulse_next;
         m_sel_reg       <= m_sel_next;
         blank_reg       <= blank_next;
         sel_changed_reg <= sel_changed_next;
         trig_miss_reg   <= trig_miss_next;
         cfg_ready_reg   <= cfg_ready_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      target_next  = target_reg;
      gcnt_next    = gcnt_reg;
      pulse_next   = pulse_reg;
      a0_next      = a0_reg;
      a1_next      = a1_reg;
      s0_next      = s0_reg;
      s1_next      = s1_reg;
      pending_next = pending_reg;
      enter_ph0    = 1'b0;

      case (state_reg)
         IDLE: begin
            pulse_next = '0;
            if (bus.EN && (pending_reg || a0_reg != '0 || a1_reg != '0))
               enter_ph0 = 1'b1;
         end
         PH0, PH1: begin
            if (!bus.EN) begin
               pulse_next = '0;
               if (m_sel_reg) begin
                  state_next  = GUARD;
                  target_next = 1'b0;
                  gcnt_next   = GUARD_LOAD;
               end else begin
                  state_next = IDLE;
               end
            end else if (bus.TRIG) begin
               if (pulse_inc == cur_len) begin
                  pulse_next = '0;
                  // An empty opposite burst keeps us on the current source.
                  if (other_len != '0) begin
                     state_next  = GUARD;
                     target_next = (state_reg == PH0);
                     gcnt_next   = GUARD_LOAD;
                  end
               end else begin
                  pulse_next = pulse_inc;
               end
            end
         end
         GUARD: begin
            pulse_next = '0;
            if (!bus.EN)
               target_next = 1'b0;
            if (gcnt_reg != '0)
               gcnt_next = gcnt_reg - 1'b1;
            else if (!bus.EN)
               state_next = IDLE;
            else if (target_reg)
               state_next = PH1;
            else
               enter_ph0 = 1'b1;
         end
         default: state_next = IDLE;
      endcase

      if (enter_ph0) begin
         a0_next      = cand_a0;
         a1_next      = cand_a1;
         pending_next = 1'b0;
         if (cand_a0 != '0) begin
            state_next = PH0;
         end else if (cand_a1 != '0) begin
            state_next  = GUARD;
            target_next = 1'b1;
            gcnt_next   = GUARD_LOAD;
         end else begin
            state_next = IDLE;
         end
      end

      // A new offer lands after the apply, so it survives as the next pending shadow.
      if (cfg_fire) begin
         s0_next      = bus.CFG_N0;
         s1_next      = bus.CFG_N1;
         pending_next = 1'b1;
      end
   end

   always_comb begin
      m_sel_next = m_sel_reg;
      if (state_next == IDLE)
         m_sel_next = 1'b0;
      else if (state_reg == GUARD && gcnt_reg != GUARD_LOAD)
         m_sel_next = bus.EN ? target_reg : 1'b0;

      // BLANK trails the state by one cycle on entry but drops with the exit edge.
      blank_next       = (state_reg == GUARD) && (state_next == GUARD);
      sel_changed_next = (m_sel_next != m_sel_reg);
      trig_miss_next   = bus.TRIG && (state_reg == GUARD);
      cfg_ready_next   = !pending_next;
   end

   assign bus.CFG_READY   = cfg_ready_reg;
   assign bus.M_SEL       = m_sel_reg;
   assign bus.BLANK       = blank_reg;
   assign bus.SEL_CHANGED = sel_changed_reg;
   assign bus.TRIG_MISS   = trig_miss_reg;
   assign bus.PULSE_CNT   = pulse_reg;

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Self-checking bench for mux_sel_scheduler: burst table, trigger miss, single-source
// bursts, shadowed reconfiguration, EN drop and reset during a guard window.
module tb_mux_sel_scheduler;
   localparam int CW = 16;
   localparam int BC = 8;

   logic CLK = 1'b0;
   logic ARESETN = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 CLK = ~CLK;

   mux_sel_scheduler_if #(.CNT_W(CW)) bus ();

   mux_sel_scheduler #(.CNT_W(CW), .BLANK_CYC(BC)) dut (
      .CLK     (CLK),
      .ARESETN (ARESETN),
      .bus     (bus)
   );

   typedef struct {
      logic msel_at;
      int   blank_cnt;
      int   chg_cnt;
      logic msel_end;
      int   pulse_end;
   } vec_t;

   vec_t tbl [9];
   vec_t sb [$];
   int   pq [$];

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " M_SEL"}, 32'(bus.M_SEL), 0);
      chk({tag, " BLANK"}, 32'(bus.BLANK), 0);
      chk({tag, " SEL_CHANGED"}, 32'(bus.SEL_CHANGED), 0);
      chk({tag, " TRIG_MISS"}, 32'(bus.TRIG_MISS), 0);
      chk({tag, " PULSE_CNT"}, 32'(bus.PULSE_CNT), 0);
      chk({tag, " CFG_READY"}, 32'(bus.CFG_READY), 1);
   endtask

   task automatic do_reset();
      bus.EN = 1'b0;
      bus.TRIG = 1'b0;
      bus.CFG_VALID = 1'b0;
      bus.CFG_N0 = '0;
      bus.CFG_N1 = '0;
      ARESETN = 1'b0;
      repeat (3) step();
      ARESETN = 1'b1;
      step();
   endtask

   task automatic load_cfg(input int n0, input int n1);
      bus.CFG_N0 = CW'(n0);
      bus.CFG_N1 = CW'(n1);
      bus.CFG_VALID = 1'b1;
      step();
      bus.CFG_VALID = 1'b0;
      chk("cfg accepted -> CFG_READY low", 32'(bus.CFG_READY), 0);
   endtask

   task automatic fire_trig();
      bus.TRIG = 1'b1;
      step();
      bus.TRIG = 1'b0;
   endtask

   // Runs n cycles with no triggers and summarises the status outputs seen.
   task automatic run_window(input int n, output int blank_cnt, output int first_blank,
                             output int chg_cnt, output int chg_at, output int miss_cnt);
      blank_cnt = 0; first_blank = -1; chg_cnt = 0; chg_at = -1; miss_cnt = 0;
      for (int j = 1; j <= n; j++) begin
         step();
         if (bus.BLANK) begin
            blank_cnt++;
            if (first_blank < 0) first_blank = j;
         end
         if (bus.SEL_CHANGED) begin
            chg_cnt++;
            chg_at = j;
         end
         if (bus.TRIG_MISS) miss_cnt++;
      end
   endtask

   initial begin
      int   bcnt, bfirst, ccnt, cat, mcnt;
      int   tot_b, tot_c;
      vec_t e;

      tbl[0] = '{1'b0, 0, 0, 1'b0, 1};
      tbl[1] = '{1'b0, 0, 0, 1'b0, 2};
      tbl[2] = '{1'b0, BC, 1, 1'b1, 0};
      tbl[3] = '{1'b1, 0, 0, 1'b1, 1};
      tbl[4] = '{1'b1, BC, 1, 1'b0, 0};
      tbl[5] = '{1'b0, 0, 0, 1'b0, 1};
      tbl[6] = '{1'b0, 0, 0, 1'b0, 2};
      tbl[7] = '{1'b0, BC, 1, 1'b1, 0};
      tbl[8] = '{1'b1, 0, 0, 1'b1, 1};

      // Reset values while held and after release
      bus.EN = 1'b0; bus.TRIG = 1'b0; bus.CFG_VALID = 1'b0;
      bus.CFG_N0 = '0; bus.CFG_N1 = '0;
      step();
      chk_reset_outputs("reset held");
      do_reset();
      chk_reset_outputs("reset released");

      // N0=3 / N1=2 burst table, one trigger per 50 cycles
      load_cfg(3, 2);
      bus.EN = 1'b1;
      step();
      chk("apply -> CFG_READY high", 32'(bus.CFG_READY), 1);
      for (int i = 0; i < 9; i++) begin
         sb.push_back(tbl[i]);
         chk($sformatf("t1 row%0d M_SEL at trig", i), 32'(bus.M_SEL), 32'(tbl[i].msel_at));
         fire_trig();
         run_window(49, bcnt, bfirst, ccnt, cat, mcnt);
         e = sb.pop_front();
         chk($sformatf("t1 row%0d BLANK cycles", i), 32'(bcnt), 32'(e.blank_cnt));
         chk($sformatf("t1 row%0d SEL_CHANGED pulses", i), 32'(ccnt), 32'(e.chg_cnt));
         chk($sformatf("t1 row%0d M_SEL end", i), 32'(bus.M_SEL), 32'(e.msel_end));
         chk($sformatf("t1 row%0d PULSE_CNT", i), 32'(bus.PULSE_CNT), 32'(e.pulse_end));
         chk($sformatf("t1 row%0d TRIG_MISS", i), 32'(mcnt), 0);
         if (e.blank_cnt != 0) begin
            chk($sformatf("t1 row%0d BLANK rise cycle", i), 32'(bfirst), 1);
            chk($sformatf("t1 row%0d SEL_CHANGED cycle", i), 32'(cat), 2);
         end
      end

      // Trigger three cycles after the PH1 burst-end trigger
      fire_trig();
      step();
      step();
      bus.TRIG = 1'b1;
      step();
      bus.TRIG = 1'b0;
      chk("t2 TRIG_MISS pulse", 32'(bus.TRIG_MISS), 1);
      step();
      chk("t2 TRIG_MISS single cycle", 32'(bus.TRIG_MISS), 0);
      run_window(40, bcnt, bfirst, ccnt, cat, mcnt);
      chk("t2 M_SEL back to 0", 32'(bus.M_SEL), 0);
      chk("t2 PULSE_CNT after guard", 32'(bus.PULSE_CNT), 0);
      fire_trig();
      chk("t2 PH0 first count", 32'(bus.PULSE_CNT), 1);

      // N0=4 / N1=0: single source, no blanking
      do_reset();
      load_cfg(4, 0);
      bus.EN = 1'b1;
      step();
      tot_b = 0; tot_c = 0;
      for (int i = 0; i < 10; i++) begin
         pq.push_back((i + 1) % 4);
         fire_trig();
         chk($sformatf("t3 trig%0d PULSE_CNT", i), 32'(bus.PULSE_CNT), 32'(pq.pop_front()));
         run_window(19, bcnt, bfirst, ccnt, cat, mcnt);
         tot_b += bcnt;
         tot_c += ccnt;
      end
      chk("t3 BLANK never", 32'(tot_b), 0);
      chk("t3 SEL_CHANGED never", 32'(tot_c), 0);
      chk("t3 M_SEL stays 0", 32'(bus.M_SEL), 0);

      // Shadowed reconfiguration offered mid-PH1
      do_reset();
      load_cfg(5, 5);
      bus.EN = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         fire_trig();
         run_window(20, bcnt, bfirst, ccnt, cat, mcnt);
      end
      chk("t4 in PH1 M_SEL", 32'(bus.M_SEL), 1);
      fire_trig();
      chk("t4 PH1 count 1", 32'(bus.PULSE_CNT), 1);
      load_cfg(1, 1);
      for (int i = 2; i <= 4; i++) begin
         fire_trig();
         chk($sformatf("t4 PH1 count %0d", i), 32'(bus.PULSE_CNT), 32'(i));
         chk($sformatf("t4 CFG_READY held low %0d", i), 32'(bus.CFG_READY), 0);
      end
      fire_trig();
      repeat (BC) step();
      chk("t4 CFG_READY low through guard", 32'(bus.CFG_READY), 0);
      chk("t4 BLANK still high", 32'(bus.BLANK), 1);
      step();
      chk("t4 CFG_READY back on PH0 entry", 32'(bus.CFG_READY), 1);
      chk("t4 BLANK low on PH0 entry", 32'(bus.BLANK), 0);
      chk("t4 M_SEL 0 in PH0", 32'(bus.M_SEL), 0);
      step();
      fire_trig();
      run_window(20, bcnt, bfirst, ccnt, cat, mcnt);
      chk("t4 new N0=1 burst ends", 32'(bcnt), BC);
      chk("t4 M_SEL after N0=1", 32'(bus.M_SEL), 1);
      fire_trig();
      run_window(20, bcnt, bfirst, ccnt, cat, mcnt);
      chk("t4 new N1=1 burst ends", 32'(bcnt), BC);
      chk("t4 M_SEL after N1=1", 32'(bus.M_SEL), 0);

      // EN dropped in PH1 after one trigger
      do_reset();
      load_cfg(1, 2);
      bus.EN = 1'b1;
      step();
      fire_trig();
      run_window(20, bcnt, bfirst, ccnt, cat, mcnt);
      chk("t5 reached PH1", 32'(bus.M_SEL), 1);
      fire_trig();
      chk("t5 PH1 count 1", 32'(bus.PULSE_CNT), 1);
      step();
      bus.EN = 1'b0;
      run_window(20, bcnt, bfirst, ccnt, cat, mcnt);
      chk("t5 guard BLANK cycles", 32'(bcnt), BC);
      chk("t5 guard BLANK rise", 32'(bfirst), 2);
      chk("t5 SEL_CHANGED cycle", 32'(cat), 3);
      chk("t5 M_SEL back to 0", 32'(bus.M_SEL), 0);
      chk("t5 PULSE_CNT cleared", 32'(bus.PULSE_CNT), 0);
      tot_b = 0; tot_c = 0;
      for (int i = 0; i < 3; i++) begin
         fire_trig();
         chk($sformatf("t5 idle trig%0d ignored", i), 32'(bus.PULSE_CNT), 0);
         run_window(10, bcnt, bfirst, ccnt, cat, mcnt);
         tot_b += bcnt + mcnt;
      end
      chk("t5 idle no BLANK or TRIG_MISS", 32'(tot_b), 0);

      // Reset asserted during a guard window with a config pending
      do_reset();
      load_cfg(1, 1);
      bus.EN = 1'b1;
      step();
      fire_trig();
      step();
      step();
      chk("t6 in guard", 32'(bus.BLANK), 1);
      load_cfg(2, 2);
      ARESETN = 1'b0;
      #1;
      chk_reset_outputs("t6 reset immediate");
      repeat (3) step();
      chk_reset_outputs("t6 reset held");
      ARESETN = 1'b1;
      tot_b = 0;
      for (int i = 0; i < 3; i++) begin
         run_window(5, bcnt, bfirst, ccnt, cat, mcnt);
         tot_b += bcnt + ccnt + mcnt;
         fire_trig();
         chk($sformatf("t6 idle trig%0d", i), 32'(bus.PULSE_CNT), 0);
      end
      chk("t6 stays idle", 32'(tot_b), 0);
      chk("t6 M_SEL idle", 32'(bus.M_SEL), 0);
      load_cfg(3, 1);
      step();
      fire_trig();
      chk("t6 new config runs", 32'(bus.PULSE_CNT), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
